// File: rtl/alu_op_sequencer.sv
// Purpose: generates {OP,A,B} vectors (sweep or 16-bit Galois LFSR) for the ALU and counts returned results.
// Latency: op_valid rises the cycle after start; zero-wait ALU gives one vector per 3 cycles (ISSUE, WAIT, NEXT).
// Backpressure: operands are held while op_ready is low; a missing result aborts the run after TIMEOUT wait cycles.
module alu_op_sequencer #(
    parameter int          WIDTH   = 5,
    parameter int          OP_W    = 2,
    parameter int          NUM_VEC = 16,
    parameter int          TIMEOUT = 15,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OP_W-1:0]  OP,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic             res_valid,
    input  logic [WIDTH:0]   res,
    output logic [WIDTH:0]   last_res,
    output logic [15:0]      vec_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int          GW   = 2*WIDTH + OP_W;
    localparam int          TW   = $clog2(TIMEOUT + 1);
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [GW-1:0]  gen;
    logic [15:0]    lfsr;
    logic [15:0]    lfsr_nxt;
    logic [TW-1:0]  timer;
    logic           mode_q;
    logic           last_vec;
    logic           timed_out;

    // The generator register is the operand output; OP sits in the top bits.
    assign {OP, A, B} = gen;

    assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    assign last_vec  = (vec_count + 16'd1) == 16'(NUM_VEC);
    assign timed_out = (timer == TW'(TIMEOUT - 1));

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a result arriving on the timeout cycle still counts.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    state_nxt = last_vec ? S_DONE : S_NEXT;
                end else if (timed_out) begin
                    state_nxt = S_DONE;
                end
            end
            S_NEXT: begin
                state_nxt = S_ISSUE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they line up with the state flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            op_valid <= (state_nxt == S_ISSUE);
            busy     <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT) || (state_nxt == S_NEXT);
            done     <= (state_nxt == S_DONE);
        end
    end

    // Datapath: generator load/advance, result timer, result capture and run counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gen       <= '0;
            lfsr      <= SEED;
            mode_q    <= 1'b0;
            timer     <= '0;
            last_res  <= '0;
            vec_count <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q    <= mode;
                        vec_count <= '0;
                        error     <= 1'b0;
                        lfsr      <= SEED;
                        gen       <= mode ? SEED[GW-1:0] : '0;
                    end
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        timer <= '0;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        last_res  <= res;
                        vec_count <= vec_count + 16'd1;
                    end else if (timed_out) begin
                        error <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (mode_q) begin
                        lfsr <= lfsr_nxt;
                        gen  <= lfsr_nxt[GW-1:0];
                    end else begin
                        gen <= gen + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: randomized self-checking bench for alu_op_sequencer, two parameter sets driven in turn.
// Latency: all stimulus is applied and all outputs are sampled on the falling clock edge.
// Backpressure: random op_ready stalls and random result latencies, including the timeout boundary.
module tb_alu_op_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          TMO  = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        op_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic [5:0]  res = '0;
    logic        sel = 1'b0;
    logic        start_a, start_b;

    logic [4:0]  a_A, a_B;
    logic [1:0]  a_OP;
    logic [5:0]  a_last;
    logic [15:0] a_cnt;
    logic        a_vld, a_busy, a_done, a_err;

    logic [1:0]  b_A, b_B;
    logic [0:0]  b_OP;
    logic [2:0]  b_last;
    logic [15:0] b_cnt;
    logic        b_vld, b_busy, b_done, b_err;

    logic [11:0] o_gen;
    logic [5:0]  o_last;
    logic [15:0] o_cnt;
    logic        o_vld, o_busy, o_done, o_err;

    int n_cmp = 0;
    int n_err = 0;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(5), .OP_W(2), .NUM_VEC(4), .TIMEOUT(TMO), .SEED(SEED)) u_big (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode),
        .A(a_A), .B(a_B), .OP(a_OP), .op_valid(a_vld), .op_ready(op_ready),
        .res_valid(res_valid), .res(res), .last_res(a_last), .vec_count(a_cnt),
        .busy(a_busy), .done(a_done), .error(a_err)
    );

    alu_op_sequencer #(.WIDTH(2), .OP_W(1), .NUM_VEC(40), .TIMEOUT(TMO), .SEED(SEED)) u_small (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode),
        .A(b_A), .B(b_B), .OP(b_OP), .op_valid(b_vld), .op_ready(op_ready),
        .res_valid(res_valid), .res(res[2:0]), .last_res(b_last), .vec_count(b_cnt),
        .busy(b_busy), .done(b_done), .error(b_err)
    );

    // Present the selected instance on one set of observation signals.
    always_comb begin
        if (!sel) begin
            o_gen  = {a_OP, a_A, a_B};
            o_last = a_last;
            o_cnt  = a_cnt;
            o_vld  = a_vld;
            o_busy = a_busy;
            o_done = a_done;
            o_err  = a_err;
        end else begin
            o_gen  = {7'd0, b_OP, b_A, b_B};
            o_last = {3'd0, b_last};
            o_cnt  = b_cnt;
            o_vld  = b_vld;
            o_busy = b_busy;
            o_done = b_done;
            o_err  = b_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    // k-th vector of a run: sweep counts up modulo 2**gw, LFSR is the seed stepped k times.
    function automatic logic [11:0] exp_vec(input bit m, input int k, input int gw);
        logic [15:0] s;
        int v;
        if (!m) begin
            v = k % (1 << gw);
        end else begin
            s = SEED;
            for (int i = 0; i < k; i++) s = lfsr_step(s);
            v = int'(s) & ((1 << gw) - 1);
        end
        return v[11:0];
    endfunction

    task automatic run(input bit m, input int rd_min, input int rd_max,
                       input int rr_min, input int rr_max, input int tmo_idx);
        int gw;
        int nvec;
        int d;
        int r;
        logic [11:0] ev;
        logic [5:0]  exp_last;
        gw   = sel ? 5 : 12;
        nvec = sel ? 40 : 4;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom_range(1, 0));
        check_eq("start_cnt", o_cnt, 0);
        check_eq("start_err", o_err, 0);
        check_eq("start_done", o_done, 0);
        for (int k = 0; k < nvec; k++) begin
            ev = exp_vec(m, k, gw);
            check_eq("issue_vld", o_vld, 1);
            check_eq("issue_busy", o_busy, 1);
            check_eq("issue_vec", o_gen, ev);
            if (!sel && m && k == 0) check_eq("lfsr_first", o_gen, 12'hCE1);
            if (!sel && m && k == 1) check_eq("lfsr_second", o_gen, 12'h270);
            if (sel && !m && k == 31) check_eq("sweep_top", o_gen, 31);
            if (sel && !m && k == 32) check_eq("sweep_wrap", o_gen, 0);
            d = $urandom_range(rd_max, rd_min);
            repeat (d) begin
                op_ready  = 1'b0;
                res_valid = 1'($urandom_range(1, 0));
                res       = 6'($urandom);
                start     = 1'($urandom_range(1, 0));
                @(negedge clk);
                check_eq("hold_vld", o_vld, 1);
                check_eq("hold_vec", o_gen, ev);
                check_eq("hold_cnt", o_cnt, k);
            end
            op_ready  = 1'b1;
            res_valid = 1'($urandom_range(1, 0));
            start     = 1'($urandom_range(1, 0));
            @(negedge clk);
            op_ready  = 1'b0;
            res_valid = 1'b0;
            start     = 1'b0;
            check_eq("hs_vld", o_vld, 0);
            check_eq("hs_cnt", o_cnt, k);
            if (k == tmo_idx) begin
                for (int c = 1; c <= TMO; c++) begin
                    check_eq("tmo_wait_done", o_done, 0);
                    check_eq("tmo_wait_busy", o_busy, 1);
                    start = 1'($urandom_range(1, 0));
                    @(negedge clk);
                end
                start = 1'b0;
                check_eq("tmo_done", o_done, 1);
                check_eq("tmo_err", o_err, 1);
                check_eq("tmo_busy", o_busy, 0);
                check_eq("tmo_cnt", o_cnt, k);
                check_eq("tmo_vec_hold", o_gen, ev);
                return;
            end
            r = $urandom_range(rr_max, rr_min);
            repeat (r) begin
                start = 1'($urandom_range(1, 0));
                @(negedge clk);
                check_eq("wait_vld", o_vld, 0);
                check_eq("wait_busy", o_busy, 1);
                check_eq("wait_cnt", o_cnt, k);
            end
            res_valid = 1'b1;
            res       = 6'($urandom);
            exp_last  = sel ? {3'd0, res[2:0]} : res;
            start     = 1'($urandom_range(1, 0));
            @(negedge clk);
            res_valid = 1'b0;
            start     = 1'b0;
            check_eq("res_cnt", o_cnt, k + 1);
            check_eq("res_last", o_last, exp_last);
            check_eq("res_err", o_err, 0);
            if (k == nvec - 1) begin
                check_eq("end_done", o_done, 1);
                check_eq("end_busy", o_busy, 0);
                check_eq("end_vld", o_vld, 0);
            end else begin
                check_eq("next_busy", o_busy, 1);
                check_eq("next_done", o_done, 0);
                res_valid = 1'($urandom_range(1, 0));
                res       = 6'($urandom);
                @(negedge clk);
            end
        end
        // Results arriving in DONE must not be counted; operands keep the last vector.
        res_valid = 1'b1;
        repeat (2) @(negedge clk);
        res_valid = 1'b0;
        check_eq("done_cnt_hold", o_cnt, nvec);
        check_eq("done_vec_hold", o_gen, exp_vec(m, nvec - 1, gw));
        check_eq("done_stays", o_done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq("rst_vld", o_vld, 0);
            check_eq("rst_busy", o_busy, 0);
            check_eq("rst_done", o_done, 0);
            check_eq("rst_err", o_err, 0);
            check_eq("rst_vec", o_gen, 0);
            check_eq("rst_cnt", o_cnt, 0);
            check_eq("rst_last", o_last, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run(1'b0, 0, 0, 0, 0, -1);
        run(1'b0, 10, 10, 0, 0, -1);
        run(1'b1, 0, 3, 0, 14, -1);
        run(1'b1, 0, 2, 0, 3, 1);
        run(1'b0, 0, 2, 14, 14, -1);
        for (int i = 0; i < 6; i++) begin
            run(1'($urandom_range(1, 0)), 0, 4, 0, 14, ($urandom_range(3, 0) == 0) ? 2 : -1);
        end

        // Abort mid-run: complete one LFSR vector, then pull reset while the second is offered.
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        op_ready = 1'b1;
        @(negedge clk);
        op_ready  = 1'b0;
        res_valid = 1'b1;
        res       = 6'h15;
        @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_pre_vld", o_vld, 1);
        check_eq("abort_pre_cnt", o_cnt, 1);
        check_eq("abort_pre_vec", o_gen, 12'h270);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_async_vld", o_vld, 0);
        check_eq("abort_async_busy", o_busy, 0);
        check_eq("abort_async_vec", o_gen, 0);
        check_eq("abort_async_cnt", o_cnt, 0);
        @(negedge clk);
        check_eq("abort_vld", o_vld, 0);
        check_eq("abort_busy", o_busy, 0);
        check_eq("abort_last", o_last, 0);
        reset = 1'b1;

        sel = 1'b1;
        run(1'b0, 0, 0, 0, 0, -1);
        run(1'b1, 0, 2, 0, 14, -1);
        run(1'b0, 0, 3, 0, 14, 7);
        run(1'b0, 0, 3, 0, 14, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
